// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU: accept, execute one cycle, hold the response.
// Accept at edge N, response valid after edge N+1; a stalled response blocks all new requests.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int OPW        = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_in1_0,
  input  logic [WIDTH-1:0] req_in2_0,
  input  logic [OPW-1:0]   req_op_0,
  input  logic [WIDTH-1:0] req_in1_1,
  input  logic [WIDTH-1:0] req_in2_1,
  input  logic [OPW-1:0]   req_op_1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             grant;
  logic             ptr;
  logic             pick;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  // Port that wins the idle-state arbitration; meaningless when nothing is valid.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b10) begin
      pick = 1'b1;
    end else if (req_valid == 2'b11) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ptr;
    end
  end

  // Gated by rst so nothing is accepted while reset is held, even though state already reads IDLE.
  assign req_ready   = (state == IDLE && !rst && |req_valid) ? (2'b01 << pick) : 2'b00;
  assign resp_valid  = (state == RESP) ? (2'b01 << grant) : 2'b00;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_op      = op_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 1'b0;
      ptr    <= 1'b0;
      in1_q  <= '0;
      in2_q  <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            in1_q <= pick ? req_in1_1 : req_in1_0;
            in2_q <= pick ? req_in2_1 : req_in2_0;
            op_q  <= pick ? req_op_1  : req_op_0;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          state  <= RESP;
        end
        RESP: begin
          // Only the granted port's acceptance matters; the pointer moves on completion only.
          if (resp_ready[grant]) begin
            ptr   <= ~grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: round-robin and fixed-priority instances, per-cycle transaction model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv [2];
  logic [1:0]  rp [2];
  logic [31:0] a0 [2];
  logic [31:0] b0 [2];
  logic [31:0] a1 [2];
  logic [31:0] b1 [2];
  logic [3:0]  o0 [2];
  logic [3:0]  o1 [2];
  logic [1:0]  rr [2];
  logic [1:0]  vv [2];
  logic [31:0] rres [2];
  logic        rz [2];
  logic [31:0] ai1 [2];
  logic [31:0] ai2 [2];
  logic [3:0]  aop [2];
  logic [31:0] ares [2];
  logic        az [2];
  logic        bsy [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state, per instance
  bit          m_ptr [2];
  bit          pend [2];
  bit          p_port [2];
  logic [31:0] p_a [2];
  logic [31:0] p_b [2];
  logic [3:0]  p_op [2];
  int          age [2];
  logic [1:0]  last_port [2];
  logic [31:0] last_res [2];
  logic        last_z [2];
  int          grants_q [$];
  logic [31:0] res_q [$];
  int          acc_q [$];

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = {31'd0, $signed(a) < $signed(b)};
      4'd9: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return {r == 32'd0, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {az[g], ares[g]} = alu_f(ai1[g], ai2[g], aop[g]);
    alu_share_arbiter #(.WIDTH(32), .OPW(4), .FIXED_PRIO(g)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(rv[g]), .req_ready(rr[g]),
      .req_in1_0(a0[g]), .req_in2_0(b0[g]), .req_op_0(o0[g]),
      .req_in1_1(a1[g]), .req_in2_1(b1[g]), .req_op_1(o1[g]),
      .resp_valid(vv[g]), .resp_ready(rp[g]),
      .resp_result(rres[g]), .resp_zero(rz[g]),
      .alu_in1(ai1[g]), .alu_in2(ai2[g]), .alu_op(aop[g]),
      .alu_result(ares[g]), .alu_zero(az[g]),
      .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] v, input bit ptr, input bit fixed);
    if (v != 2'b11) return v;
    if (fixed) return 2'b01;
    return ptr ? 2'b10 : 2'b01;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 1'b0;
      pend[d]  = 1'b0;
      age[d]   = 0;
    end
  endtask

  // Drive (optionally random) inputs each cycle and check every output against the model.
  task automatic stream(input int d, input int n, input bit rnd);
    logic [1:0]  exp_rr;
    logic [32:0] e;
    for (int c = 0; c < n; c++) begin
      if (rnd) begin
        rv[d] = 2'($urandom_range(0, 3));
        rp[d] = 2'($urandom_range(0, 3));
        a0[d] = $urandom; b0[d] = 32'($urandom_range(0, 40));
        a1[d] = $urandom; b1[d] = $urandom;
        o0[d] = 4'($urandom_range(0, 9));
        o1[d] = 4'($urandom_range(0, 9));
      end
      #1;
      if (!pend[d]) begin
        exp_rr = arb(rv[d], m_ptr[d], d == 1);
        chk("idle_req_ready", {30'd0, rr[d]}, {30'd0, exp_rr});
        chk("idle_resp_valid", {30'd0, vv[d]}, 32'd0);
        chk("idle_busy", {31'd0, bsy[d]}, 32'd0);
        if (exp_rr != 2'b00) begin
          p_port[d] = exp_rr[1];
          p_a[d]  = exp_rr[1] ? a1[d] : a0[d];
          p_b[d]  = exp_rr[1] ? b1[d] : b0[d];
          p_op[d] = exp_rr[1] ? o1[d] : o0[d];
          pend[d] = 1'b1;
          age[d]  = -1;
          grants_q.push_back(int'(exp_rr[1]));
          acc_q.push_back(cyc);
        end
      end else if (age[d] == 0) begin
        chk("exec_req_ready", {30'd0, rr[d]}, 32'd0);
        chk("exec_resp_valid", {30'd0, vv[d]}, 32'd0);
        chk("exec_busy", {31'd0, bsy[d]}, 32'd1);
        chk("exec_alu_in1", ai1[d], p_a[d]);
        chk("exec_alu_in2", ai2[d], p_b[d]);
        chk("exec_alu_op", {28'd0, aop[d]}, {28'd0, p_op[d]});
      end else begin
        e = alu_f(p_a[d], p_b[d], p_op[d]);
        chk("resp_req_ready", {30'd0, rr[d]}, 32'd0);
        chk("resp_valid", {30'd0, vv[d]}, p_port[d] ? 32'd2 : 32'd1);
        chk("resp_result", rres[d], e[31:0]);
        chk("resp_zero", {31'd0, rz[d]}, {31'd0, e[32]});
        chk("resp_busy", {31'd0, bsy[d]}, 32'd1);
        if (rp[d][p_port[d]]) begin
          last_port[d] = {1'b0, p_port[d]};
          last_res[d]  = rres[d];
          last_z[d]    = rz[d];
          res_q.push_back(rres[d]);
          m_ptr[d] = ~p_port[d];
          pend[d]  = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend[d]) age[d]++;
    end
  endtask

  task automatic clr();
    grants_q.delete();
    res_q.delete();
    acc_q.delete();
    last_port[0] = 2'd3;
    last_port[1] = 2'd3;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; rp[d] = '0;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
      o0[d] = '0; o1[d] = '0;
    end
    m_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {30'd0, rr[d]}, 32'd0);
      chk("rst_resp_valid", {30'd0, vv[d]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[d]}, 32'd0);
      chk("rst_alu_in1", ai1[d], 32'd0);
      chk("rst_alu_in2", ai2[d], 32'd0);
      chk("rst_alu_op", {28'd0, aop[d]}, 32'd0);
      chk("rst_result", rres[d], 32'd0);
      chk("rst_zero", {31'd0, rz[d]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Port 0 alone: 5 + 7
    clr();
    a0[0] = 32'd5; b0[0] = 32'd7; o0[0] = 4'd0;
    rv[0] = 2'b01; rp[0] = 2'b01;
    stream(0, 3, 1'b0);
    rv[0] = 2'b00;
    chk("t1_port", {30'd0, last_port[0]}, 32'd0);
    chk("t1_result", last_res[0], 32'd12);
    chk("t1_zero", {31'd0, last_z[0]}, 32'd0);

    // Port 1 alone: 9 - 9
    clr();
    a1[0] = 32'd9; b1[0] = 32'd9; o1[0] = 4'd1;
    rv[0] = 2'b10; rp[0] = 2'b10;
    stream(0, 3, 1'b0);
    rv[0] = 2'b00;
    chk("t2_port", {30'd0, last_port[0]}, 32'd1);
    chk("t2_result", last_res[0], 32'd0);
    chk("t2_zero", {31'd0, last_z[0]}, 32'd1);

    // Both continuously valid, round-robin
    clr();
    a0[0] = 32'hF0; b0[0] = 32'h0F; o0[0] = 4'd3;
    a1[0] = 32'hFFFF_FFF8; b1[0] = 32'd1; o1[0] = 4'd7;
    rv[0] = 2'b11; rp[0] = 2'b11;
    stream(0, 12, 1'b0);
    rv[0] = 2'b00;
    chk("t3_grant_count", grants_q.size(), 32'd4);
    chk("t3_result_count", res_q.size(), 32'd4);
    for (int i = 0; i < grants_q.size(); i++) begin
      chk("t3_grant_alternates", grants_q[i], i % 2);
      if (i > 0) chk("t3_accept_spacing", acc_q[i] - acc_q[i-1], 32'd3);
    end
    for (int i = 0; i < res_q.size(); i++)
      chk("t3_result", res_q[i], (i % 2) ? 32'hFFFF_FFFC : 32'h0000_00FF);

    // Back-pressure on port 0 while port 1 waits
    clr();
    a0[0] = 32'h1234; b0[0] = 32'h1111; o0[0] = 4'd4;
    a1[0] = 32'd3; b1[0] = 32'd4; o1[0] = 4'd0;
    rv[0] = 2'b01; rp[0] = 2'b00;
    stream(0, 1, 1'b0);
    rv[0] = 2'b10;
    stream(0, 6, 1'b0);
    chk("bp_hold_result", rres[0], 32'h0325);
    chk("bp_hold_valid", {30'd0, vv[0]}, 32'd1);
    chk("bp_hold_busy", {31'd0, bsy[0]}, 32'd1);
    chk("bp_hold_req_ready", {30'd0, rr[0]}, 32'd0);
    rp[0] = 2'b01;
    stream(0, 1, 1'b0);
    chk("bp_release_port", {30'd0, last_port[0]}, 32'd0);
    chk("bp_release_result", last_res[0], 32'h0325);
    rp[0] = 2'b11;
    stream(0, 3, 1'b0);
    rv[0] = 2'b00;
    chk("bp_next_port", {30'd0, last_port[0]}, 32'd1);
    chk("bp_next_result", last_res[0], 32'd7);

    // Reset in the middle of a transaction
    clr();
    a0[0] = 32'd77; b0[0] = 32'd1; o0[0] = 4'd0;
    rv[0] = 2'b01; rp[0] = 2'b11;
    stream(0, 1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {30'd0, rr[0]}, 32'd0);
    chk("mid_rst_resp_valid", {30'd0, vv[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
    chk("mid_rst_alu_in1", ai1[0], 32'd0);
    chk("mid_rst_alu_op", {28'd0, aop[0]}, 32'd0);
    m_reset();
    rv[0] = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a1[0] = 32'hFFFF_FFFF; b1[0] = 32'd0; o1[0] = 4'd8;
    rv[0] = 2'b10;
    stream(0, 3, 1'b0);
    rv[0] = 2'b00;
    chk("post_rst_port", {30'd0, last_port[0]}, 32'd1);
    chk("post_rst_slt", last_res[0], 32'd1);
    chk("post_rst_zero", {31'd0, last_z[0]}, 32'd0);

    // Randomized traffic against the model
    clr();
    stream(0, 400, 1'b1);
    rv[0] = 2'b00; rp[0] = 2'b11;
    stream(0, 4, 1'b0);
    chk("rand_some_traffic", {31'd0, grants_q.size() > 20}, 32'd1);

    // Fixed priority instance: port 0 always wins
    clr();
    a0[1] = 32'd10; b0[1] = 32'd3; o0[1] = 4'd1;
    a1[1] = 32'd1; b1[1] = 32'd1; o1[1] = 4'd0;
    rv[1] = 2'b11; rp[1] = 2'b11;
    stream(1, 9, 1'b0);
    rv[1] = 2'b00;
    chk("fp_grant_count", grants_q.size(), 32'd3);
    for (int i = 0; i < grants_q.size(); i++)
      chk("fp_grant_port0", grants_q[i], 32'd0);
    for (int i = 0; i < res_q.size(); i++)
      chk("fp_result", res_q[i], 32'd7);
    stream(1, 200, 1'b1);
    rv[1] = 2'b00; rp[1] = 2'b11;
    stream(1, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (4-bit op encoding, result plus zero flag) between two requesters, e.g. main execute path (port 0) and an address/auxiliary unit (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Block arbitrates, registers operands, drives the shared ALU for one cycle, captures result and zero flag, then returns them to the granted requester.
- Sits between requesters and the ALU instance; the ALU itself stays outside this block.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, ALU op-code width.
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port request accept; at most one bit high.
- req_in1_0, req_in2_0  in  WIDTH each  port 0 operands.
- req_op_0  in  OPW  port 0 op.
- req_in1_1, req_in2_1  in  WIDTH each  port 1 operands.
- req_op_1  in  OPW  port 1 op.
- resp_valid  out  2  per-port response valid; at most one bit high.
- resp_ready  in  2  per-port response accept.
- resp_result  out  WIDTH  captured ALU result (shared bus, qualified by resp_valid).
- resp_zero  out  1  captured ALU zero flag.
- alu_in1, alu_in2  out  WIDTH  to shared ALU.
- alu_op  out  OPW  to shared ALU.
- alu_result  in  WIDTH  from shared ALU (combinational).
- alu_zero  in  1  from shared ALU.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE, grant = 0, priority pointer = port 0.
  - Operand, op, result and zero registers = 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - alu_in1/alu_in2/alu_op = 0 (driven from registers).
- States:
  - IDLE: req_ready is combinational.
    - Single requester: that bit is high.
    - Both requesting: the priority-pointer port wins (FIXED_PRIO=1 -> port 0 always).
    - Handshake (req_valid[i] & req_ready[i]) latches in1, in2, op and grant = i; next state EXEC.
    - No request: stay IDLE.
  - EXEC: alu_in1/alu_in2/alu_op come from the latched registers. At the clock edge, alu_result/alu_zero are captured into the result registers; next state RESP. req_ready = 0.
  - RESP: resp_valid[grant] = 1, resp_result/resp_zero come from the captured registers and stay stable until accepted.
    - On resp_ready[grant]: next state IDLE; round-robin pointer moves to the other port (pointer = ~grant).
    - resp_ready on the non-granted port is ignored.
- Latency and throughput:
  - Request accepted at edge N -> resp_valid high from after edge N+1 -> earliest new accept in cycle N+3.
  - Minimum 3 cycles per transaction; one transaction in flight.
- Back-pressure: RESP holds indefinitely while resp_ready[grant] = 0; no requests accepted meanwhile.
- Starvation freedom: with FIXED_PRIO=0 and both ports continuously valid, grants strictly alternate 0,1,0,1...
- The pointer updates only on response completion, never on a request that is not accepted.
- req_valid dropped without a handshake has no effect.
- A request's operands are sampled only at the accept edge; later changes are ignored.
- rst asserted mid-transaction (EXEC or RESP): transaction is dropped, no response issued, all outputs return to reset values immediately.
- Outside EXEC, alu_in1/alu_in2/alu_op keep the last latched values; the ALU is never driven from unregistered requester inputs.
- Widths: no arithmetic inside the block; result passes through unmodified at WIDTH bits.

Test Plan:
- Port 0 only: in1=5, in2=7, op=0000 (ADD) -> req_ready[0] in accept cycle; resp_valid[0] 2 cycles later; resp_result=12, resp_zero=0.
- Port 1 only: in1=9, in2=9, op=0001 (SUB) -> resp_valid[1] with resp_result=0, resp_zero=1; resp_valid[0] stays 0 throughout.
- Both valid continuously, FIXED_PRIO=0, resp_ready tied high:
  - Port 0 ops: in1=0xF0, in2=0x0F, op=0011 (OR).
  - Port 1 ops: in1=-8 (0xFFFFFFF8), in2=1, op=0111 (SRA).
  - Required: grants alternate 0,1,0,1; results 0xFF and 0xFFFFFFFC; new accept every 3 cycles.
- Back-pressure: hold resp_ready[0]=0 for 5 cycles in RESP -> resp_valid[0], resp_result stable and busy=1 throughout; req_ready=0 even with req_valid[1]=1; accept completes on the cycle resp_ready[0] rises.
- Reset mid-op: assert rst in EXEC cycle (no clock edge needed) -> resp_valid=0, req_ready=0, busy=0 immediately; after release, a new port 1 request (SLT, in1=-1, in2=0) returns resp_result=1.
- FIXED_PRIO=1, both ports continuously valid -> port 0 granted every transaction; port 1 never gets req_ready.
